// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and beat type for the skid stage
package pipe_pkg;

  localparam int PIPE_PAYLOAD_W = 32;
  localparam int PIPE_RADDR_W   = 5;

  typedef struct packed {
    logic                    valid;
    logic [PIPE_RADDR_W-1:0] rd;
    logic [PIPE_PAYLOAD_W-1:0] data;
  } pipe_beat_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one beat register with load, clear and optional zero-on-clear
module pipe_slot #(
  parameter int W             = 37,
  parameter bit ZERO_ON_CLEAR = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // clear beats load so a flush always wins
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (ZERO_ON_CLEAR) data_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-slot skid pipeline stage; PIPE_FLUSH_ZERO_EN zeroes slots on flush
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int RADDR_W   = PIPE_RADDR_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [PAYLOAD_W-1:0] IN_DATA,
  input  logic [RADDR_W-1:0]   IN_RD,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [PAYLOAD_W-1:0] OUT_DATA,
  output logic [RADDR_W-1:0]   OUT_RD,
  output logic [1:0]           OCC
);

  localparam int BW = RADDR_W + PAYLOAD_W;
`ifdef PIPE_FLUSH_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic          m_valid, s_valid;
  logic [BW-1:0] m_q, s_q, m_d, in_beat;
  logic          m_load, m_clear, s_load, s_clear;
  logic          in_fire, out_fire;

  assign in_beat  = {IN_RD, IN_DATA};
  // s_valid is a flop, so IN_READY never sees OUT_READY combinationally
  assign IN_READY = !s_valid;
  assign in_fire  = IN_VALID && IN_READY;
  assign out_fire = m_valid && OUT_READY;

  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_beat;
    if (FLUSH) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (s_valid) begin
      if (out_fire) begin
        m_load  = 1'b1;
        m_d     = s_q;
        s_clear = 1'b1;
      end
    end else if (m_valid) begin
      if (in_fire && out_fire) m_load  = 1'b1;
      else if (in_fire)        s_load  = 1'b1;
      else if (out_fire)       m_clear = 1'b1;
    end else if (in_fire) begin
      m_load = 1'b1;
    end
  end

  pipe_slot #(.W(BW), .ZERO_ON_CLEAR(ZERO_EN)) u_main (
    .clk     (CLK),
    .rst_n   (RST),
    .load_i  (m_load),
    .clear_i (m_clear),
    .d_i     (m_d),
    .valid_o (m_valid),
    .q_o     (m_q)
  );

  pipe_slot #(.W(BW), .ZERO_ON_CLEAR(ZERO_EN)) u_skid (
    .clk     (CLK),
    .rst_n   (RST),
    .load_i  (s_load),
    .clear_i (s_clear),
    .d_i     (in_beat),
    .valid_o (s_valid),
    .q_o     (s_q)
  );

  assign OUT_VALID = m_valid;
  assign OUT_RD    = m_q[BW-1 -: RADDR_W];
  assign OUT_DATA  = m_q[PAYLOAD_W-1:0];
  assign OCC       = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed and random scoreboard bench for pipe_skid_stage
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  logic        CLK = 1'b0, RST = 1'b0, FLUSH = 1'b0;
  logic        IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic        IN_READY, OUT_VALID;
  logic [31:0] IN_DATA = '0, OUT_DATA;
  logic [4:0]  IN_RD = '0, OUT_RD;
  logic [1:0]  OCC;

  int total = 0;
  int bad   = 0;
  pipe_beat_t sb[$];
  pipe_beat_t exp_b;

  always #5 CLK = ~CLK;

  pipe_skid_stage dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_RD(IN_RD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_RD(OUT_RD),
    .OCC(OCC)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard bookkeeping before the edge, occupancy checks just after it.
  task automatic cycle();
    if (OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {27'd0, OUT_RD, OUT_DATA}, 64'hdead);
      end else begin
        exp_b = sb.pop_front();
        chk("out_data", {32'd0, OUT_DATA}, {32'd0, exp_b.data});
        chk("out_rd", {59'd0, OUT_RD}, {59'd0, exp_b.rd});
      end
    end
    if (FLUSH) sb.delete();
    else if (IN_VALID && IN_READY) sb.push_back('{valid: 1'b1, rd: IN_RD, data: IN_DATA});
    @(posedge CLK);
    #1;
    chk("occ", {62'd0, OCC}, 64'(sb.size()));
    chk("out_valid", {63'd0, OUT_VALID}, {63'd0, sb.size() != 0});
    chk("in_ready", {63'd0, IN_READY}, {63'd0, sb.size() < 2});
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] rd);
    IN_VALID = 1'b1; IN_DATA = d; IN_RD = rd;
    cycle();
    IN_VALID = 1'b0;
  endtask

  initial begin
    // reset values while held
    #2;
    chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("rst_occ", {62'd0, OCC}, 64'd0);
    chk("rst_in_ready", {63'd0, IN_READY}, 64'd1);
    chk("rst_out_data", {32'd0, OUT_DATA}, 64'd0);
    chk("rst_out_rd", {59'd0, OUT_RD}, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // single beat, latency 1
    OUT_READY = 1'b1;
    send(32'h11, 5'd3);
    chk("first_data", {32'd0, OUT_DATA}, 64'h11);
    chk("first_rd", {59'd0, OUT_RD}, 64'd3);
    chk("first_occ", {62'd0, OCC}, 64'd1);
    cycle();

    // streaming at one beat per cycle
    for (int i = 1; i <= 8; i++) begin
      IN_VALID = 1'b1; IN_DATA = i; IN_RD = 5'(i);
      cycle();
      chk("stream_in_ready", {63'd0, IN_READY}, 64'd1);
      chk("stream_out_data", {32'd0, OUT_DATA}, 64'(i));
    end
    IN_VALID = 1'b0;
    cycle();
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // stall fills skid, then drain in order
    OUT_READY = 1'b0;
    send(32'hA, 5'd1);
    send(32'hB, 5'd2);
    chk("stall_occ", {62'd0, OCC}, 64'd2);
    chk("stall_in_ready", {63'd0, IN_READY}, 64'd0);
    chk("stall_head", {32'd0, OUT_DATA}, 64'hA);
    cycle();
    chk("stall_hold", {32'd0, OUT_DATA}, 64'hA);
    OUT_READY = 1'b1;
    cycle();
    chk("after_a_in_ready", {63'd0, IN_READY}, 64'd1);
    chk("after_a_head", {32'd0, OUT_DATA}, 64'hB);
    cycle();

    // flush with a concurrent input beat
    OUT_READY = 1'b0;
    send(32'h21, 5'd4);
    send(32'h22, 5'd5);
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 32'hC; IN_RD = 5'd6;
    cycle();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("flush_occ", {62'd0, OCC}, 64'd0);
    chk("flush_out_valid", {63'd0, OUT_VALID}, 64'd0);
`ifdef PIPE_FLUSH_ZERO_EN
    chk("flush_zero_data", {32'd0, OUT_DATA}, 64'd0);
    chk("flush_zero_rd", {59'd0, OUT_RD}, 64'd0);
`endif
    OUT_READY = 1'b1;
    repeat (3) cycle();

    // asynchronous reset mid-stream
    OUT_READY = 1'b0;
    send(32'h31, 5'd7);
    send(32'h32, 5'd8);
    #2 RST = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    chk("arst_in_ready", {63'd0, IN_READY}, 64'd1);
    chk("arst_occ", {62'd0, OCC}, 64'd0);
    sb.delete();
    RST = 1'b1;
    OUT_READY = 1'b1;
    send(32'hD, 5'd9);
    chk("post_rst_data", {32'd0, OUT_DATA}, 64'hD);
    chk("post_rst_valid", {63'd0, OUT_VALID}, 64'd1);
    cycle();

    // random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      IN_VALID  = ($urandom_range(0, 99) < 60);
      OUT_READY = ($urandom_range(0, 99) < 55);
      FLUSH     = ($urandom_range(0, 127) == 0);
      IN_DATA   = $urandom;
      IN_RD     = 5'($urandom);
      cycle();
    end
    IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
    repeat (3) cycle();
    chk("final_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 32, width of the data payload.
REQ-002 SHALL have parameter RADDR_W, default 5, width of the destination-register tag.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port FLUSH  input  1  synchronous kill of all held beats.
REQ-006 SHALL have port IN_VALID  input  1  upstream beat present.
REQ-007 SHALL have port IN_READY  output  1  stage accepts a beat this cycle.
REQ-008 SHALL have port IN_DATA  input  PAYLOAD_W  upstream payload.
REQ-009 SHALL have port IN_RD  input  RADDR_W  upstream destination tag.
REQ-010 SHALL have port OUT_VALID  output  1  downstream beat present.
REQ-011 SHALL have port OUT_READY  input  1  downstream accepts.
REQ-012 SHALL have port OUT_DATA  output  PAYLOAD_W  head payload.
REQ-013 SHALL have port OUT_RD  output  RADDR_W  head tag, for hazard detection.
REQ-014 SHALL have port OCC  output  2  number of held beats, 0..2.

Function
REQ-015 SHALL hold two slots: main M, which drives the OUT_* ports, and skid S.
REQ-016 SHALL drive IN_READY as the registered value of !S.valid, with no combinational path from OUT_READY.
REQ-017 SHALL treat the input as fired when IN_VALID&IN_READY, and the output as fired when OUT_VALID&OUT_READY.
REQ-018 SHALL set OUT_VALID=M.valid and OCC=M.valid+S.valid.
REQ-019 SHALL, when M is empty and the input fires, load M next cycle (latency 1).
REQ-020 SHALL, when M is full, the input fires and the output fires, load M with the input, giving throughput of 1 beat/cycle.
REQ-021 SHALL, when M is full, the input fires and the output does not fire, load S with the input; IN_READY is 0 the next cycle.
REQ-022 SHALL, when both M and S are full and the output fires, move S into M and clear S.
REQ-023 SHALL, when M is full, S is empty, the output fires and there is no input, empty M.
REQ-024 SHALL keep M and S contents stable while the output is stalled; no beat is lost or duplicated.
REQ-025 SHALL, when FLUSH=1, take top priority: clear M.valid and S.valid at the edge, discard any input fire that cycle, and set IN_READY=1 next cycle.
REQ-026 SHALL keep beats in order: S is always younger than M.

Reset
REQ-027 SHALL, while RST=0, immediately force M.valid=0, S.valid=0, OUT_VALID=0, OCC=0, IN_READY=1, OUT_DATA=0 and OUT_RD=0.
REQ-028 SHALL abandon any in-flight beats when reset is asserted mid-transfer, and resume normal operation on the first edge after RST rises.

Configuration
REQ-029 SHALL, with PIPE_FLUSH_ZERO_EN defined, zero the payload and tag of both slots on FLUSH, so OUT_DATA and OUT_RD read 0 after a flush.
REQ-030 SHALL, without PIPE_FLUSH_ZERO_EN, clear only the valid bits on FLUSH and leave stale payload and tag, which are don't-care while OUT_VALID=0.

Structure
REQ-031 SHALL place PAYLOAD_W and RADDR_W defaults, and a pipe_beat_t typedef (valid, rd, data), in shared package pipe_pkg.
REQ-032 SHALL instantiate one sub-module, pipe_slot, twice: a single register slot with load, clear and optional zero-on-clear.

Verification
REQ-033 SHALL cover: reset, then IN_DATA=0x11, IN_RD=3, IN_VALID=1, OUT_READY=1 -> OUT_VALID=1, OUT_DATA=0x11, OUT_RD=3 one cycle later, OCC=1.
REQ-034 SHALL cover: streaming 0x1..0x8 with OUT_READY=1 -> 8 beats out in order on 8 consecutive cycles with IN_READY held at 1.
REQ-035 SHALL cover: OUT_READY=0 while 0xA then 0xB are sent -> OCC=2, IN_READY=0, OUT_DATA=0xA; then OUT_READY=1 -> 0xA, then 0xB, and IN_READY=1 after 0xA leaves.
REQ-036 SHALL cover: OCC=2, then FLUSH=1 with IN_VALID=1, IN_DATA=0xC -> next cycle OCC=0, OUT_VALID=0, and 0xC is never output; with the macro, OUT_DATA=0.
REQ-037 SHALL cover: RST pulsed low mid-stream with OCC=2 -> OUT_VALID=0 and IN_READY=1 immediately; the next beat 0xD appears with latency 1.
REQ-038 SHALL cover: random IN_VALID and OUT_READY over 10k cycles -> the output sequence equals the accepted-input sequence minus flushed beats.
